// File: rtl/gen3_tx_frame_scheduler.sv
// Gen3 transmit framing scheduler for one lane.
// Arbitrates TLP vs DLLP requesters (round-robin on ties) and serialises the
// granted packet as STP/payload/END|EDB or SDP/DLLP/end bytes, one byte per
// tx_ready cycle. Handshake: a byte moves only on a rising edge with
// tx_ready=1; with tx_ready=0 everything holds and valid drops for that edge.
module gen3_tx_frame_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_ready,
    input  logic        tlp_req,
    input  logic [9:0]  tlp_len_dw,
    input  logic [11:0] tlp_seq,
    input  logic        tlp_nullify,
    input  logic [7:0]  tlp_data,
    output logic        tlp_gnt,
    output logic        tlp_data_rd,
    input  logic        dllp_req,
    input  logic [47:0] dllp_data,
    output logic        dllp_gnt,
    output logic [7:0]  data_out,
    output logic        valid,
    output logic [1:0]  syncHeader,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STP,
        S_TLP_PAY,
        S_TLP_END,
        S_SDP,
        S_DLLP_PAY,
        S_DLLP_END
    } state_t;

    // Each state names the byte(s) emitted on the edges taken from it; the
    // first framing byte is emitted by the granting edge out of IDLE.
    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        last_dllp_q, last_dllp_d;
    logic [11:0] len_q, len_d;
    logic [11:0] seq_q, seq_d;
    logic        null_q, null_d;
    logic [47:0] dllp_q, dllp_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        tlp_gnt_q, tlp_gnt_d;
    logic        dllp_gnt_q, dllp_gnt_d;

    logic        pay_last;
    logic        pick_tlp;

    // Payload length in bytes is 4*L; 12 bits is enough for 4*1023.
    assign pay_last = (cnt_q == ({len_q[9:0], 2'b00} - 12'd1));
    // TLP wins when alone, or on a tie when the DLLP side was granted last.
    assign pick_tlp = tlp_req && (!dllp_req || last_dllp_q);

    // Next-state, datapath and strobe decode; everything holds unless tx_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dllp_d = last_dllp_q;
        len_d       = len_q;
        seq_d       = seq_q;
        null_d      = null_q;
        dllp_d      = dllp_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        tlp_gnt_d   = 1'b0;
        dllp_gnt_d  = 1'b0;
        tlp_data_rd = 1'b0;
        if (tx_ready) begin
            case (state_q)
                S_IDLE: begin
                    // The cycle showing a terminator is not an arbitration
                    // slot, which gives the one-cycle gap between frames.
                    if (!valid_q) begin
                        if (pick_tlp) begin
                            len_d       = {2'b00, tlp_len_dw};
                            seq_d       = tlp_seq;
                            null_d      = tlp_nullify;
                            data_out_d  = {tlp_len_dw[3:0], 4'hF};
                            valid_d     = 1'b1;
                            tlp_gnt_d   = 1'b1;
                            last_dllp_d = 1'b0;
                            state_d     = S_STP;
                            cnt_d       = 12'd0;
                        end else if (dllp_req) begin
                            dllp_d      = dllp_data;
                            data_out_d  = 8'hF0;
                            valid_d     = 1'b1;
                            dllp_gnt_d  = 1'b1;
                            last_dllp_d = 1'b1;
                            state_d     = S_SDP;
                            cnt_d       = 12'd0;
                        end
                    end
                end
                S_STP: begin
                    valid_d = 1'b1;
                    case (cnt_q[1:0])
                        2'd0:    data_out_d = len_q[11:4];
                        2'd1:    data_out_d = {4'h0, seq_q[11:8]};
                        default: data_out_d = seq_q[7:0];
                    endcase
                    if (cnt_q == 12'd2) begin
                        cnt_d   = 12'd0;
                        state_d = (len_q == 12'd0) ? S_TLP_END : S_TLP_PAY;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_TLP_PAY: begin
                    tlp_data_rd = 1'b1;
                    data_out_d  = tlp_data;
                    valid_d     = 1'b1;
                    if (pay_last) begin
                        cnt_d   = 12'd0;
                        state_d = S_TLP_END;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_TLP_END: begin
                    data_out_d = null_q ? 8'hC0 : 8'h1F;
                    valid_d    = 1'b1;
                    cnt_d      = 12'd0;
                    state_d    = S_IDLE;
                end
                S_SDP: begin
                    data_out_d = 8'hAC;
                    valid_d    = 1'b1;
                    cnt_d      = 12'd0;
                    state_d    = S_DLLP_PAY;
                end
                S_DLLP_PAY: begin
                    data_out_d = dllp_q[{cnt_q[2:0], 3'b000} +: 8];
                    valid_d    = 1'b1;
                    if (cnt_q == 12'd5) begin
                        cnt_d   = 12'd0;
                        state_d = S_DLLP_END;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_DLLP_END: begin
                    data_out_d = 8'h00;
                    valid_d    = 1'b1;
                    cnt_d      = 12'd0;
                    state_d    = S_IDLE;
                end
                default: begin
                    cnt_d   = 12'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 12'd0;
            last_dllp_q <= 1'b1;
            len_q       <= 12'd0;
            seq_q       <= 12'd0;
            null_q      <= 1'b0;
            dllp_q      <= 48'd0;
            data_out_q  <= 8'h00;
            valid_q     <= 1'b0;
            tlp_gnt_q   <= 1'b0;
            dllp_gnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dllp_q <= last_dllp_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            null_q      <= null_d;
            dllp_q      <= dllp_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            tlp_gnt_q   <= tlp_gnt_d;
            dllp_gnt_q  <= dllp_gnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign syncHeader = valid_q ? 2'b01 : 2'b00;
    assign tlp_gnt    = tlp_gnt_q;
    assign dllp_gnt   = dllp_gnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gen3_tx_frame_scheduler.sv
// Bench for gen3_tx_frame_scheduler: frame-level byte model, negedge monitor,
// directed scenarios with literal expectations.
module tb_gen3_tx_frame_scheduler;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_ready;
    logic        tlp_req;
    logic [9:0]  tlp_len_dw;
    logic [11:0] tlp_seq;
    logic        tlp_nullify;
    logic [7:0]  tlp_data;
    logic        tlp_gnt;
    logic        tlp_data_rd;
    logic        dllp_req;
    logic [47:0] dllp_data;
    logic        dllp_gnt;
    logic [7:0]  data_out;
    logic        valid;
    logic [1:0]  syncHeader;
    logic        busy;

    always #5 clk = ~clk;

    gen3_tx_frame_scheduler dut (
        .clk(clk), .rst(rst), .tx_ready(tx_ready),
        .tlp_req(tlp_req), .tlp_len_dw(tlp_len_dw), .tlp_seq(tlp_seq),
        .tlp_nullify(tlp_nullify), .tlp_data(tlp_data), .tlp_gnt(tlp_gnt),
        .tlp_data_rd(tlp_data_rd), .dllp_req(dllp_req), .dllp_data(dllp_data),
        .dllp_gnt(dllp_gnt), .data_out(data_out), .valid(valid),
        .syncHeader(syncHeader), .busy(busy)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          run_q[$];
    int          gap_q[$];
    int          gnt_log[$];
    int          exp_order[$];
    int          rd_cnt, cur_run, zero_run;
    bit          seen_valid, rd_pend;
    logic [7:0]  pay_mem [64];
    int          pay_idx;
    bit          model_last_dllp;
    logic [7:0]  e_byte;

    logic [7:0] lit_tlp  [13] = '{8'h2F, 8'h00, 8'h01, 8'h23, 8'h01, 8'h02, 8'h03,
                                  8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1F};
    logic [7:0] lit_dllp [9]  = '{8'hF0, 8'hAC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                  8'h66, 8'h00};
    logic [7:0] lit_null [5]  = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'hC0};

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- frame model ----------------
    task automatic push_tlp(input int len, input logic [11:0] seq, input bit nul, input int pay_start);
        logic [11:0] l;
        l = 12'(len);
        exp_q.push_back({l[3:0], 4'hF});
        exp_q.push_back(l[11:4]);
        exp_q.push_back({4'h0, seq[11:8]});
        exp_q.push_back(seq[7:0]);
        for (int i = 0; i < 4 * len; i++) exp_q.push_back(pay_mem[(pay_start + i) % 64]);
        exp_q.push_back(nul ? 8'hC0 : 8'h1F);
    endtask

    task automatic push_dllp(input logic [47:0] d);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hAC);
        for (int i = 0; i < 6; i++) exp_q.push_back(d[8*i +: 8]);
        exp_q.push_back(8'h00);
    endtask

    // ---------------- monitor / compare process ----------------
    always @(negedge clk) begin
        check_eq("sync_header", syncHeader, valid ? 2'b01 : 2'b00);
        if (valid) begin
            got_q.push_back(data_out);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_byte: got 0x%0h, expected no byte", data_out);
            end else begin
                e_byte = exp_q.pop_front();
                check_eq("stream_byte", data_out, e_byte);
            end
            if (zero_run > 0 && seen_valid) gap_q.push_back(zero_run);
            zero_run   = 0;
            seen_valid = 1'b1;
            cur_run++;
        end else begin
            if (cur_run > 0) run_q.push_back(cur_run);
            cur_run = 0;
            zero_run++;
        end
        if (tlp_gnt) begin
            gnt_log.push_back(0);
            check_eq("tlp_gnt_with_stp", {dllp_gnt, valid, data_out[3:0]}, {1'b0, 1'b1, 4'hF});
        end
        if (dllp_gnt) begin
            gnt_log.push_back(1);
            check_eq("dllp_gnt_with_sdp", {valid, data_out}, {1'b1, 8'hF0});
        end
        if (tlp_data_rd) begin
            rd_cnt++;
            check_eq("rd_needs_ready", tx_ready, 1'b1);
        end
        rd_pend = tlp_data_rd;
    end

    // First-word-fall-through payload source: advance after each pop edge.
    always @(posedge clk) begin
        if (rd_pend) begin
            #1;
            pay_idx++;
            tlp_data = pay_mem[pay_idx % 64];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_payload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) pay_mem[i] = base + 8'(i);
        pay_idx  = 0;
        tlp_data = pay_mem[0];
    endtask

    task automatic clear_logs();
        got_q.delete(); run_q.delete(); gap_q.delete(); gnt_log.delete();
        exp_order.delete();
        rd_cnt = 0; cur_run = 0; zero_run = 0; seen_valid = 1'b0;
    endtask

    task automatic wait_gnt(input bit is_dllp, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        repeat (60) begin
            @(negedge clk);
            cyc++;
            if (is_dllp ? dllp_gnt : tlp_gnt) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(is_dllp ? "dllp_gnt_seen" : "tlp_gnt_seen", seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("frame_drained", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_byte(input logic [7:0] b);
        bit ok = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (valid && data_out == b) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("byte_seen", ok, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int n_tlp;
        rst = 1'b1; tx_ready = 1'b1;
        tlp_req = 1'b0; tlp_len_dw = '0; tlp_seq = '0; tlp_nullify = 1'b0;
        dllp_req = 1'b0; dllp_data = '0;
        rd_pend = 1'b0;
        load_payload(8'h01, 8);
        clear_logs();
        step(2);
        @(negedge clk);
        check_eq("reset_outputs", {data_out, valid, syncHeader, tlp_gnt, dllp_gnt, tlp_data_rd, busy},
                 {8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        model_last_dllp = 1'b1;
        step(1);

        // TLP, normal
        clear_logs();
        load_payload(8'h01, 8);
        push_tlp(2, 12'h123, 1'b0, 0);
        tlp_len_dw = 10'd2; tlp_seq = 12'h123; tlp_nullify = 1'b0; tlp_req = 1'b1;
        wait_gnt(1'b0, cyc);
        tlp_req = 1'b0; tlp_len_dw = 10'h3FF; tlp_seq = 12'hFFF; tlp_nullify = 1'b1;
        check_eq("tlp_gnt_latency", cyc, 2);
        wait_idle();
        check_eq("tlp_rd_count", rd_cnt, 8);
        check_eq("tlp_run_count", run_q.size(), 1);
        if (run_q.size() == 1) check_eq("tlp_run_len", run_q[0], 13);
        check_eq("tlp_bytes", got_q.size(), 13);
        if (got_q.size() == 13) for (int i = 0; i < 13; i++) check_eq("tlp_literal", got_q[i], lit_tlp[i]);

        // DLLP
        clear_logs();
        push_dllp(48'h665544332211);
        dllp_data = 48'h665544332211; dllp_req = 1'b1;
        wait_gnt(1'b1, cyc);
        dllp_req = 1'b0; dllp_data = '0;
        check_eq("dllp_gnt_latency", cyc, 2);
        wait_idle();
        check_eq("dllp_bytes", got_q.size(), 9);
        if (got_q.size() == 9) for (int i = 0; i < 9; i++) check_eq("dllp_literal", got_q[i], lit_dllp[i]);

        // Tie arbitration, both requests held from reset
        rst = 1'b1;
        load_payload(8'hA1, 8);
        tlp_len_dw = 10'd1; tlp_seq = 12'h0AB; tlp_nullify = 1'b0; tlp_req = 1'b1;
        dllp_data = 48'hC6C5C4C3C2C1; dllp_req = 1'b1;
        step(2);
        clear_logs();
        model_last_dllp = 1'b1;
        n_tlp = 0;
        for (int k = 0; k < 4; k++) begin
            if (model_last_dllp) begin
                push_tlp(1, 12'h0AB, 1'b0, 4 * n_tlp);
                n_tlp++;
                exp_order.push_back(0);
                model_last_dllp = 1'b0;
            end else begin
                push_dllp(48'hC6C5C4C3C2C1);
                exp_order.push_back(1);
                model_last_dllp = 1'b1;
            end
        end
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (gnt_log.size() >= 4) break;
        end
        check_eq("tie_four_grants", gnt_log.size(), 4);
        @(posedge clk); #1;
        tlp_req = 1'b0; dllp_req = 1'b0;
        wait_idle();
        if (gnt_log.size() == 4) for (int i = 0; i < 4; i++) check_eq("tie_order", gnt_log[i], exp_order[i]);
        check_eq("tie_runs", run_q.size(), 4);
        if (run_q.size() == 4) for (int i = 0; i < 4; i++) check_eq("tie_run_len", run_q[i], 9);
        check_eq("tie_gaps", gap_q.size(), 3);
        if (gap_q.size() == 3) for (int i = 0; i < 3; i++) check_eq("tie_gap_len", gap_q[i], 1);
        check_eq("tie_rd_count", rd_cnt, 8);

        // Nullified zero-length TLP
        clear_logs();
        push_tlp(0, 12'h000, 1'b1, 0);
        tlp_len_dw = 10'd0; tlp_seq = 12'h000; tlp_nullify = 1'b1; tlp_req = 1'b1;
        wait_gnt(1'b0, cyc);
        tlp_req = 1'b0; tlp_nullify = 1'b0;
        wait_idle();
        check_eq("null_rd_count", rd_cnt, 0);
        check_eq("null_bytes", got_q.size(), 5);
        if (got_q.size() == 5) for (int i = 0; i < 5; i++) check_eq("null_literal", got_q[i], lit_null[i]);

        // Stall after payload byte 03
        clear_logs();
        load_payload(8'h01, 8);
        push_tlp(2, 12'h123, 1'b0, 0);
        tlp_len_dw = 10'd2; tlp_seq = 12'h123; tlp_nullify = 1'b0; tlp_req = 1'b1;
        wait_gnt(1'b0, cyc);
        tlp_req = 1'b0;
        step(5);
        tx_ready = 1'b0;
        @(negedge clk);
        check_eq("stall_last_before", {valid, data_out, tlp_data_rd}, {1'b1, 8'h03, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) tx_ready = 1'b1;
            @(negedge clk);
            check_eq("stall_valid_low", valid, 1'b0);
            if (i < 2) check_eq("stall_rd_low", tlp_data_rd, 1'b0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("stall_resume", {valid, data_out}, {1'b1, 8'h04});
        wait_idle();
        check_eq("stall_rd_count", rd_cnt, 8);
        check_eq("stall_gaps", gap_q.size(), 1);
        if (gap_q.size() == 1) check_eq("stall_gap_len", gap_q[0], 3);
        check_eq("stall_bytes", got_q.size(), 13);
        if (got_q.size() == 13) for (int i = 0; i < 13; i++) check_eq("stall_literal", got_q[i], lit_tlp[i]);

        // Reset mid-frame, request still high: DLLP restarts from F0
        clear_logs();
        push_dllp(48'h0605040302A1);
        dllp_data = 48'h0605040302A1; dllp_req = 1'b1;
        wait_byte(8'hAC);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_mid_outputs", {valid, busy, data_out, syncHeader, dllp_gnt},
                 {1'b0, 1'b0, 8'h00, 2'b00, 1'b0});
        exp_q.delete();
        push_dllp(48'h0605040302A1);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_gnt(1'b1, cyc);
        dllp_req = 1'b0;
        check_eq("rst_restart_latency", cyc, 2);
        wait_idle();

        // Reset mid-frame, request dropped: no restart
        push_dllp(48'h0605040302A1);
        dllp_req = 1'b1;
        wait_byte(8'hAC);
        @(posedge clk); #1;
        rst = 1'b1; dllp_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_drop_outputs", {valid, busy}, {1'b0, 1'b0});
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        step(12);
        check_eq("rst_drop_no_grant", gnt_log.size(), 0);
        check_eq("rst_drop_no_bytes", got_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gen3_tx_frame_scheduler.md
# gen3_tx_frame_scheduler

Gen3 transmit-side framing scheduler for one lane. It arbitrates between a TLP requester and a DLLP requester and serialises the granted packet into a byte stream with Gen3 framing tokens (STP/END/EDB for TLPs, SDP for DLLPs). Its output is byte-compatible with the receive-side Gen3 byte checker, so the two blocks connect back-to-back in loopback benches.

## Interface
- No parameters. Lane width is fixed at 8 bits.
- clk  in  1  sole clock; everything is sampled on its rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_ready  in  1  downstream accept. When low, the block stalls.
- tlp_req  in  1  TLP request. Held high until tlp_gnt.
- tlp_len_dw  in  10  TLP payload length in DW. 0..1023 is legal.
- tlp_seq  in  12  sequence number carried in STP bytes 2 and 3.
- tlp_nullify  in  1  1 = terminate the TLP with EDB instead of END.
- tlp_data  in  8  payload byte. Must be valid in any cycle where tlp_data_rd=1 (first-word-fall-through FIFO).
- tlp_gnt  out  1  one-cycle pulse when a TLP frame is started.
- tlp_data_rd  out  1  payload pop strobe.
- dllp_req  in  1  DLLP request. Held high until dllp_gnt.
- dllp_data  in  48  DLLP plus CRC. Bits [7:0] are sent first.
- dllp_gnt  out  1  one-cycle pulse when a DLLP frame is started.
- data_out  out  8  output byte.
- valid  out  1  data_out is valid.
- syncHeader  out  2  2'b01 whenever valid=1, 2'b00 otherwise.
- busy  out  1  high when the state is anything other than IDLE.

## Operation
- States: IDLE, STP, TLP_PAY, TLP_END, SDP, DLLP_PAY, DLLP_END.
- A 12-bit byte counter indexes bytes within each state. It is cleared on every state entry.
- Arbitration happens in IDLE only, and only when tx_ready=1.
  - Single request: that requester wins.
  - Both requesting: round-robin. The requester not granted last time wins.
  - A last-grant pointer records the winner and updates at every grant.
- Grant actions:
  - Pulse the matching gnt.
  - Latch len, seq and nullify (TLP) or dllp_data (DLLP) into internal registers.
  - The inputs are don't-care after the grant.
- TLP frame bytes, in order (L = {2'b00, tlp_len_dw}):
  - STP byte 0: {L[3:0], 4'hF}
  - STP byte 1: L[11:4]
  - STP byte 2: {4'h0, seq[11:8]}
  - STP byte 3: seq[7:0]
  - Then 4·L payload bytes taken from tlp_data.
  - Then one terminator: 8'h1F (END) if nullify=0, 8'hC0 (EDB) if nullify=1.
  - L=0 skips TLP_PAY and goes straight to TLP_END.
- DLLP frame bytes, in order:
  - 8'hF0, 8'hAC
  - dllp_data bytes 0..5
  - 8'h00 as the DLLP end byte
  - 9 bytes total.
- tlp_data_rd is combinational. It is 1 only in TLP_PAY with tx_ready=1. The strobed byte is registered into data_out at that edge.
- Payload byte count arithmetic is 12-bit: 4·L never exceeds 4092, so there is no wrap.
- After TLP_END or DLLP_END, the next state is IDLE.

## Timing
- Reset values:
  - state IDLE, counter 0
  - data_out 8'h00, valid 0, syncHeader 2'b00
  - tlp_gnt, dllp_gnt, tlp_data_rd, busy all 0
  - last-grant pointer = DLLP, so the first tie goes to the TLP requester.
- Latency: with req high in cycle N (IDLE, tx_ready=1):
  - gnt is high in cycle N+1.
  - The first token byte is on data_out with valid=1 in cycle N+1.
- Gaps and throughput:
  - Frames are contiguous: one valid byte per tx_ready cycle.
  - Minimum inter-frame gap is one cycle with valid=0 (the IDLE cycle).
  - Total TLP length is 5+4L bytes. Total DLLP length is 9 bytes.
- Stall (tx_ready=0):
  - state, counter and data_out hold.
  - valid=0, tlp_data_rd=0, no grant.
  - On resume, the next byte follows with no loss or duplication.
- Request timing:
  - A request arriving mid-frame waits for IDLE.
  - Dropping a request before its grant is legal and causes no grant.
- rst mid-frame: at the next edge all outputs take their reset values. The frame is abandoned with no END.

## Test plan
- **TLP, normal:** rst, then tlp_req with len=2, seq=12'h123, nullify=0, payload 01..08.
  - Output: 2F 00 01 23 01 02 03 04 05 06 07 08 1F, 13 consecutive valid bytes.
  - tlp_data_rd is high for exactly 8 cycles.
- **DLLP:** dllp_data=48'h665544332211.
  - Output: F0 AC 11 22 33 44 55 66 00.
  - dllp_gnt is high in the same cycle as F0.
- **Tie arbitration:** both requests held from reset.
  - Frame order: TLP, DLLP, TLP, DLLP.
  - Exactly one valid=0 cycle between consecutive frames.
- **Nullified zero-length TLP:** len=0, nullify=1, seq=0.
  - Output: 0F 00 00 00 C0.
  - tlp_data_rd is never asserted.
- **Stall:** tx_ready=0 for 3 cycles after payload byte 03 of the first test.
  - valid=0 and tlp_data_rd=0 for those 3 cycles.
  - The stream then resumes at 04 and ends with 1F.
- **Reset mid-frame:** rst asserted after the SDP byte 0xAC.
  - Next cycle: valid=0, busy=0.
  - The DLLP restarts from F0 only if dllp_req is still high after rst is released.
